// File: rtl/autosym_sweep_sig.sv
// Exhaustive minterm sweeper + MISR/on-set compactor for 1-output PLA netlists; SWEEP_GRAY_EN selects Gray-order x.
// Latency: done pulses (SETTLE+1)*2^N_IN cycles after the start edge; each minterm is held SETTLE+1 cycles.
// Backpressure: none; start is only accepted in IDLE and ignored while busy or done.
module autosym_sweep_sig #(
    parameter int              N_IN   = 9,
    parameter int              SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY  = 16'h1021,
    parameter logic [SIG_W-1:0] SEED  = '1,
    parameter int              SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SIG_W-1:0]  golden_sig,
    input  logic              y0,
    output logic [N_IN-1:0]   x,
    output logic              busy,
    output logic              done,
    output logic [SIG_W-1:0]  signature,
    output logic [N_IN:0]     ones_count,
    output logic              match
);

    typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

    localparam logic [N_IN-1:0] LAST     = '1;
    localparam logic [3:0]      SETTLE_C = 4'(SETTLE);

    state_t            state, state_nx;
    logic [N_IN-1:0]   index, index_nx;
    logic [3:0]        hold, hold_nx;
    logic [SIG_W-1:0]  signature_nx;
    logic [N_IN:0]     ones_nx;
    logic              match_nx;
    logic              fb;
    logic [SIG_W-1:0]  misr;

    assign fb   = signature[SIG_W-1] ^ y0;
    assign misr = {signature[SIG_W-2:0], 1'b0} ^ (fb ? POLY : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            index      <= '0;
            hold       <= '0;
            signature  <= SEED;
            ones_count <= '0;
            match      <= 1'b0;
        end else begin
            state      <= state_nx;
            index      <= index_nx;
            hold       <= hold_nx;
            signature  <= signature_nx;
            ones_count <= ones_nx;
            match      <= match_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        index_nx     = index;
        hold_nx      = hold;
        signature_nx = signature;
        ones_nx      = ones_count;
        match_nx     = match;
        case (state)
            IDLE: begin
                if (start) begin
                    index_nx     = '0;
                    hold_nx      = '0;
                    signature_nx = SEED;
                    ones_nx      = '0;
                    match_nx     = 1'b0;
                    state_nx     = HOLD;
                end
            end
            HOLD: begin
                if (hold < SETTLE_C) begin
                    hold_nx = hold + 4'd1;
                end else begin
                    // sample edge: y0 has been stable for SETTLE+1 cycles
                    signature_nx = misr;
                    ones_nx      = ones_count + {{N_IN{1'b0}}, y0};
                    if (index == LAST) begin
                        state_nx = DONE;
                        match_nx = (misr == golden_sig);
                    end else begin
                        index_nx = index + 1'b1;
                        hold_nx  = '0;
                    end
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state == HOLD);
    assign done = (state == DONE);

`ifdef SWEEP_GRAY_EN
    assign x = index ^ (index >> 1);
`else
    assign x = index;
`endif

endmodule

// File: tb/tb_autosym_sweep_sig.sv
// Directed bench for autosym_sweep_sig: default instance (SETTLE=1) plus a SETTLE=3 instance.
module tb_autosym_sweep_sig;

    logic        clk = 1'b0;
    logic        rst, start, y0;
    logic [15:0] golden;
    logic [8:0]  x;
    logic        busy, done, match;
    logic [15:0] sig;
    logic [9:0]  ones;

    logic        start3, y03;
    logic [15:0] golden3;
    logic [8:0]  x3;
    logic        busy3, done3, match3;
    logic [15:0] sig3;
    logic [9:0]  ones3;

    int vectors = 0;
    int miscompares = 0;
    int mode = 0;

    always #5 clk = ~clk;

    autosym_sweep_sig dut (
        .clk(clk), .rst(rst), .start(start), .golden_sig(golden), .y0(y0),
        .x(x), .busy(busy), .done(done), .signature(sig), .ones_count(ones), .match(match)
    );

    autosym_sweep_sig #(.SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .golden_sig(golden3), .y0(y03),
        .x(x3), .busy(busy3), .done(done3), .signature(sig3), .ones_count(ones3), .match(match3)
    );

    // netlists under test: 3 = original, 4 = rewritten equivalent, 5 = rewritten with one faulty minterm
    function automatic logic f(input int m, input logic [8:0] v);
        logic a, b;
        a = v[0] & v[1];
        b = v[2] ^ v[8];
        case (m)
            0:       return 1'b1;
            1:       return v[0];
            2:       return &v;
            3:       return a | b;
            4:       return ~(~a & ~b);
            5:       return ~(~a & ~b) ^ (v == 9'h0A5);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [8:0] xexp(input int i);
        logic [8:0] v;
        v = i[8:0];
`ifdef SWEEP_GRAY_EN
        return v ^ (v >> 1);
`else
        return v;
`endif
    endfunction

    function automatic logic [15:0] model_sig(input int m);
        logic [15:0] s;
        logic        fb;
        s = 16'hFFFF;
        for (int i = 0; i < 512; i++) begin
            fb = s[15] ^ f(m, xexp(i));
            s  = {s[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return s;
    endfunction

    always_comb y0  = f(mode, x);
    always_comb y03 = x3[0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs one sweep on the default instance; optionally pulses start mid-sweep at edge count poke.
    task automatic run_sweep(input logic [15:0] g, input int poke);
        int n, bad;
        logic got;
        golden = g;
        n = 0; bad = 0; got = 1'b0;
        @(negedge clk); start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        while (n < 1100) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (!busy || x !== xexp(n / 2)) bad++;
            start = (n == poke);
            @(posedge clk); n++;
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_seen", 32'(got), 32'd1);
        chk("done_latency", n, 32'd1024);
        chk("x_sequence_errors", bad, 32'd0);
    endtask

    // Start asserted during the done cycle must not launch a new sweep.
    task automatic check_done_tail();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("start_in_done_ignored", 32'(busy), 32'd0);
    endtask

    initial begin
        int n, bad, dseen;
        logic [15:0] e;
        rst = 1'b1; start = 1'b0; start3 = 1'b0; golden = '0; golden3 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_x", 32'(x), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_sig", 32'(sig), 32'hFFFF);
        chk("rst_ones", 32'(ones), 32'd0);
        chk("rst_match", 32'(match), 32'd0);
        rst = 1'b0;

        // y0 = 1, start poked mid-sweep
        mode = 0; e = model_sig(0);
        run_sweep(e, 100);
        chk("ones_all", 32'(ones), 32'd512);
        chk("sig_all", 32'(sig), 32'(e));
        chk("match_all", 32'(match), 32'd1);
        check_done_tail();

        // y0 = x[0], golden with one bit flipped
        mode = 1; e = model_sig(1);
        run_sweep(e ^ 16'h0001, -1);
        chk("ones_x0", 32'(ones), 32'd256);
        chk("sig_x0", 32'(sig), 32'(e));
        chk("match_x0_flipped", 32'(match), 32'd0);

        mode = 2; e = model_sig(2);
        run_sweep(e, -1);
        chk("ones_and", 32'(ones), 32'd1);
        chk("sig_and", 32'(sig), 32'(e));
        chk("match_and", 32'(match), 32'd1);

        // original vs rewritten netlist, then single-minterm fault at x=0A5
        e = model_sig(3);
        mode = 3; run_sweep(e, -1);
        chk("ones_orig", 32'(ones), 32'd320);
        chk("sig_orig", 32'(sig), 32'(e));
        chk("match_orig", 32'(match), 32'd1);
        mode = 4; run_sweep(e, -1);
        chk("sig_opt", 32'(sig), 32'(e));
        chk("match_opt", 32'(match), 32'd1);
        mode = 5; run_sweep(e, -1);
        chk("ones_fault", 32'(ones), 32'd319);
        chk("match_fault", 32'(match), 32'd0);

        // reset 300 cycles into a sweep
        mode = 2;
        @(negedge clk); start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (299) @(posedge clk);
        @(negedge clk);
        chk("pre_abort_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_x", 32'(x), 32'd0);
        chk("abort_sig", 32'(sig), 32'hFFFF);
        chk("abort_ones", 32'(ones), 32'd0);
        dseen = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) dseen++;
            @(negedge clk);
        end
        chk("abort_no_done", dseen, 32'd0);
        e = model_sig(2);
        run_sweep(e, -1);
        chk("after_abort_ones", 32'(ones), 32'd1);
        chk("after_abort_match", 32'(match), 32'd1);

        // SETTLE=3 instance with a start pulse while busy
        golden3 = model_sig(1);
        @(negedge clk); start3 = 1'b1;
        @(posedge clk);
        @(negedge clk); start3 = 1'b0;
        n = 0; bad = 0;
        while (n < 2200 && !done3) begin
            if (!busy3 || x3 !== xexp(n / 4)) bad++;
            start3 = (n == 500);
            @(posedge clk); n++;
            @(negedge clk);
        end
        start3 = 1'b0;
        chk("s3_done_latency", n, 32'd2048);
        chk("s3_x_sequence_errors", bad, 32'd0);
        chk("s3_ones", 32'(ones3), 32'd256);
        chk("s3_sig", 32'(sig3), 32'(golden3));
        chk("s3_match", 32'(match3), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
